// File: rtl/vec_bus_pkg.sv
// Vector memory bus packet types and helpers shared by the vector bus blocks.
package vec_bus_pkg;

  typedef logic [3:0]  BusID;
  typedef logic [63:0] VectorValue;

  typedef enum logic [2:0] {
    vec_idle             = 3'd0,
    read_vec64           = 3'd1,
    write_vec64          = 3'd2,
    read_response_vec64  = 3'd3,
    write_response_vec64 = 3'd4
  } VecBusPacketType;

  typedef struct packed {
    VecBusPacketType ptype;
    BusID            source;
    logic [31:0]     addr;
    VectorValue      data;
  } VecBusPacket;

  localparam int unsigned VecBusPacketWidth = $bits(VecBusPacket);

  typedef enum logic [0:0] {
    RspEmpty = 1'b0,
    RspFull  = 1'b1
  } rsp_state_e;

  function automatic logic is_vec_req_type(VecBusPacketType t);
    return (t == read_vec64) || (t == write_vec64);
  endfunction

  function automatic logic is_vec_rsp_type(VecBusPacketType t);
    return (t == read_response_vec64) || (t == write_response_vec64);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic        found;
  int unsigned k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = 32'(ptr) + off;
      if (k >= N) k = k - N;
      if (!found && eligible[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/vec_memory_bus_arbiter.sv
// Shares one vector memory bus among NUM_REQ requesters: RR request arbitration into a
// one-entry output register, responses routed back by source BusID with per-requester credits.
module vec_memory_bus_arbiter
  import vec_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BASE_ID   = 0,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*VecBusPacketWidth-1:0] req_pkt,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 mem_req_valid,
  output logic [VecBusPacketWidth-1:0]         mem_req_pkt,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_rsp_valid,
  input  logic [VecBusPacketWidth-1:0]         mem_rsp_pkt,
  output logic                                 mem_rsp_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [VecBusPacketWidth-1:0]         rsp_pkt,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic                                 err_pulse
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  VecBusPacket        req_p [NUM_REQ];
  logic [NUM_REQ-1:0] legal, eligible, illegal, grant, drop_oh, dec;
  logic [IdxW-1:0]    grant_idx, ptr_q, ptr_d;
  logic [CntW-1:0]    outst_q [NUM_REQ];
  logic [CntW-1:0]    outst_d [NUM_REQ];
  logic               can_load, grant_any;

  logic               mem_valid_q, mem_valid_d;
  VecBusPacket        mem_pkt_q, mem_pkt_d;

  rsp_state_e         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  VecBusPacket        rsp_pkt_q, rsp_pkt_d;
  VecBusPacket        rsp_in;
  logic [31:0]        rel;
  logic [IdxW-1:0]    rsp_idx;
  logic               in_range, same_dec, credit_ok, rsp_ok;
  logic               rsp_hs, rsp_take, rsp_err, mem_rsp_ready_int;
  logic [NUM_REQ-1:0] rsp_valid_int;

  assign can_load = !mem_valid_q || mem_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_p[i]    = req_pkt[i*VecBusPacketWidth +: VecBusPacketWidth];
      legal[i]    = is_vec_req_type(req_p[i].ptype);
      eligible[i] = req_valid[i] && legal[i] && can_load &&
                    (outst_q[i] < CntW'(MAX_OUTST));
      illegal[i]  = req_valid[i] && !legal[i];
    end
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign grant_any = |grant;
  // Illegal requests are only flushed on cycles without a grant, lowest index first.
  assign drop_oh   = grant_any ? '0 : (illegal & (~illegal + NUM_REQ'(1)));

  always_comb begin
    mem_valid_d = mem_valid_q && !mem_req_ready;
    mem_pkt_d   = mem_pkt_q;
    ptr_d       = ptr_q;
    if (grant_any) begin
      mem_valid_d      = 1'b1;
      mem_pkt_d        = req_p[grant_idx];
      mem_pkt_d.source = BusID'(BASE_ID + 32'(grant_idx));
      ptr_d            = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
    end
  end

  // Response side: decode source into a requester index and qualify against its credits.
  always_comb begin
    rsp_in    = mem_rsp_pkt;
    rel       = 32'(rsp_in.source) - BASE_ID;
    in_range  = (32'(rsp_in.source) >= BASE_ID) && (rel < NUM_REQ);
    rsp_idx   = rel[IdxW-1:0];
    rsp_hs    = (state_q == RspFull) && rsp_ready[idx_q];
    // A credit being returned this cycle by the same requester is no longer available.
    same_dec  = rsp_hs && (idx_q == rsp_idx);
    credit_ok = outst_q[rsp_idx] > CntW'(same_dec);
    rsp_ok    = in_range && is_vec_rsp_type(rsp_in.ptype) && credit_ok;
    mem_rsp_ready_int = (state_q == RspEmpty) || rsp_ready[idx_q];
    rsp_take  = mem_rsp_valid && mem_rsp_ready_int;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rsp_pkt_d = rsp_pkt_q;
    rsp_err   = 1'b0;
    if (rsp_hs) state_d = RspEmpty;
    if (rsp_take) begin
      if (rsp_ok) begin
        state_d   = RspFull;
        idx_d     = rsp_idx;
        rsp_pkt_d = rsp_in;
      end else begin
        rsp_err = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_int = '0;
    if (state_q == RspFull) rsp_valid_int[idx_q] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i] = rsp_valid_int[i] && rsp_ready[i] && (outst_q[i] != '0);
      unique case ({grant[i], dec[i]})
        2'b10:   outst_d[i] = outst_q[i] + CntW'(1);
        2'b01:   outst_d[i] = outst_q[i] - CntW'(1);
        default: outst_d[i] = outst_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_pkt_q   <= '0;
      state_q     <= RspEmpty;
      idx_q       <= '0;
      rsp_pkt_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_valid_q <= mem_valid_d;
      mem_pkt_q   <= mem_pkt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_pkt_q   <= rsp_pkt_d;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out of a flushed state.
  always_comb begin
    req_ready     = reset ? '0 : (grant | drop_oh);
    mem_req_valid = !reset && mem_valid_q;
    mem_req_pkt   = reset ? '0 : mem_pkt_q;
    mem_rsp_ready = !reset && mem_rsp_ready_int;
    rsp_valid     = reset ? '0 : rsp_valid_int;
    rsp_pkt       = reset ? '0 : rsp_pkt_q;
    err_pulse     = !reset && ((|drop_oh) || rsp_err);
  end

endmodule

// File: tb/tb_vec_memory_bus_arbiter.sv
// Table-driven bench for vec_memory_bus_arbiter with request and response scoreboards.
module tb_vec_memory_bus_arbiter;
  import vec_bus_pkg::*;

  localparam int unsigned NumReq   = 4;
  localparam int unsigned BaseId   = 4;
  localparam int unsigned MaxOutst = 2;
  localparam int unsigned W        = VecBusPacketWidth;

  logic              clk, reset;
  logic [NumReq-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NumReq*W-1:0] req_pkt;
  logic              mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, err_pulse;
  logic [W-1:0]      mem_req_pkt, mem_rsp_pkt, rsp_pkt;

  vec_memory_bus_arbiter #(
    .NUM_REQ  (NumReq),
    .BASE_ID  (BaseId),
    .MAX_OUTST(MaxOutst)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_pkt      (req_pkt),
    .req_ready    (req_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_pkt  (mem_req_pkt),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_pkt  (mem_rsp_pkt),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_pkt      (rsp_pkt),
    .rsp_ready    (rsp_ready),
    .err_pulse    (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] rv;     // req_valid
    logic [3:0] bad;    // requesters presenting an illegal type
    logic       mr;     // mem_req_ready
    logic       mvi;    // mem_rsp_valid
    logic [3:0] rsrc;   // response source
    logic       rbad;   // response carries a non-response type
    logic [3:0] rri;    // rsp_ready
    logic       rkeep;  // response expected to be latched
    logic [3:0] e_rr;
    logic       e_mv;
    logic [3:0] e_rv;
    logic       e_mrr;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [3:0]  oh;
    VecBusPacket pkt;
  } rsp_exp_t;

  VecBusPacket req_sb[$];
  rsp_exp_t    rsp_sb[$];
  vec_t        tbl[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic vec_t r(int rst, int rv, int bad, int mr, int mvi, int rsrc, int rbad,
                             int rri, int rkeep, int e_rr, int e_mv, int e_rv, int e_mrr,
                             int e_err);
    vec_t v;
    v.rst = 1'(rst);   v.rv = 4'(rv);     v.bad = 4'(bad);   v.mr = 1'(mr);
    v.mvi = 1'(mvi);   v.rsrc = 4'(rsrc); v.rbad = 1'(rbad); v.rri = 4'(rri);
    v.rkeep = 1'(rkeep);
    v.e_rr = 4'(e_rr); v.e_mv = 1'(e_mv); v.e_rv = 4'(e_rv); v.e_mrr = 1'(e_mrr);
    v.e_err = 1'(e_err);
    return v;
  endfunction

  function automatic VecBusPacket mkpkt(VecBusPacketType t, BusID src, logic [31:0] addr,
                                        VectorValue data);
    VecBusPacket p;
    p.ptype = t; p.source = src; p.addr = addr; p.data = data;
    return p;
  endfunction

  function automatic VecBusPacket req_of(int n, int i, logic bad);
    VecBusPacketType t;
    if (bad) t = read_response_vec64;
    else if (i % 2 == 1) t = write_vec64;
    else t = read_vec64;
    return mkpkt(t, 4'hF, 32'(n * 16 + i), {32'(n), 32'(i) ^ 32'hA5A5_0000});
  endfunction

  function automatic VecBusPacket rsp_of(int n, logic [3:0] src, logic rbad);
    VecBusPacketType t;
    if (rbad) t = read_vec64;
    else if (n % 2 == 1) t = write_response_vec64;
    else t = read_response_vec64;
    return mkpkt(t, src, 32'h1000 + 32'(n), {32'hBEEF_0000 + 32'(n), 32'(n)});
  endfunction

  task automatic chk(input string name, input int n, input logic [127:0] act,
                     input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic miss(input string name, input int n);
    tests_run++;
    tests_failed++;
    $display("FAIL %s row %0d: output present but scoreboard empty", name, n);
  endtask

  task automatic apply(input vec_t v, input int n);
    rsp_exp_t e;
    VecBusPacket p;
    reset         = v.rst;
    req_valid     = v.rv;
    mem_req_ready = v.mr;
    mem_rsp_valid = v.mvi;
    rsp_ready     = v.rri;
    for (int i = 0; i < NumReq; i++) req_pkt[i*W +: W] = req_of(n, i, v.bad[i]);
    mem_rsp_pkt = rsp_of(n, v.rsrc, v.rbad);
    #1;
    chk("req_ready", n, 128'(req_ready), 128'(v.e_rr));
    chk("mem_req_valid", n, 128'(mem_req_valid), 128'(v.e_mv));
    chk("rsp_valid", n, 128'(rsp_valid), 128'(v.e_rv));
    chk("mem_rsp_ready", n, 128'(mem_rsp_ready), 128'(v.e_mrr));
    chk("err_pulse", n, 128'(err_pulse), 128'(v.e_err));
    if (v.e_mv) begin
      if (req_sb.size() == 0) miss("mem_req_pkt", n);
      else begin
        chk("mem_req_pkt", n, 128'(mem_req_pkt), 128'(req_sb[0]));
        if (v.mr) void'(req_sb.pop_front());
      end
    end
    if (v.e_rv != 4'd0) begin
      if (rsp_sb.size() == 0) miss("rsp_pkt", n);
      else begin
        chk("rsp_pkt", n, 128'(rsp_pkt), 128'(rsp_sb[0].pkt));
        chk("rsp_route", n, 128'(rsp_valid), 128'(rsp_sb[0].oh));
        if ((v.e_rv & v.rri) != 4'd0) void'(rsp_sb.pop_front());
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (v.e_rr[i] && !v.bad[i]) begin
        p = req_of(n, i, 1'b0);
        p.source = BusID'(BaseId + 32'(i));
        req_sb.push_back(p);
      end
    end
    if (v.rkeep) begin
      e.oh  = 4'(32'd1 << (32'(v.rsrc) - BaseId));
      e.pkt = rsp_of(n, v.rsrc, v.rbad);
      rsp_sb.push_back(e);
    end
    if (v.rst) begin
      req_sb.delete();
      rsp_sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    reset = 1'b1; req_valid = '1; req_pkt = '0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_pkt = '0; rsp_ready = '0;

    //              rst rv  bad mr mvi src rb rri kp | e_rr mv e_rv mrr err
    // Reset held with all requesters active
    for (int i = 0; i < 3; i++) tbl.push_back(r(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Round-robin fairness until every requester holds MaxOutst credits
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Response routing: sources 2,0,2 with the consumer blocked three cycles
    tbl.push_back(r(0, 0, 0, 1, 1, 6, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(r(0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(r(0, 0, 0, 1, 1, 4, 0, 4, 1, 0, 0, 4, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(r(0, 0, 0, 1, 1, 6, 0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 4, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Errors: unknown source, no credit, bad response type, illegal request type
    tbl.push_back(r(0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(r(0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(r(0, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(r(0, 2, 2, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 1));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 5, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(r(0, 4, 4, 1, 0, 0, 0, 0, 0, 4, 1, 0, 1, 1));
    tbl.push_back(r(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Backpressure after the first grant, then a reset that must flush without replay
    for (int i = 0; i < 2; i++) tbl.push_back(r(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(r(0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 15, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(r(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Credit limit with requester 1 alone
    tbl.push_back(r(0, 2, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
    tbl.push_back(r(0, 2, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(r(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(r(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    @(posedge clk);
    #1;
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    // Credit release: requester 1 stays blocked until its response handshakes
    h = r(0, 2, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0, 1, 0); apply(h, 1000);
    h = r(0, 2, 0, 1, 0, 0, 0, 2, 0, 0, 0, 2, 1, 0); apply(h, 1001);
    h = r(0, 2, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0); apply(h, 1002);
    h = r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); apply(h, 1003);
    h = r(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); apply(h, 1004);

    chk("req_sb_drained", 2000, 128'(req_sb.size()), 128'(0));
    chk("rsp_sb_drained", 2001, 128'(rsp_sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
